// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. It accepts a and b with a
//   start/done handshake. Each clock it processes one CHUNK-bit slice, least
//   significant slice first, on a narrow ripple datapath. The carry between
//   slices is held in a register. Subtraction is a + ~b + ~cin, so in sub mode
//   cout is the no-borrow flag.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request; accepted only in IDLE or DONE
//   sub             0: a + b + cin, 1: a - b - cin (captured on accept)
//   a, b, cin       operands, captured on accept
//   busy            high while slices are being processed
//   done            one-cycle pulse; sum/cout/ovf valid from here to next accept
//   sum, cout, ovf  result, carry out of MSB, signed overflow

// One bit of the ripple chain; CHUNK of these form the per-slice adder.
module chunked_serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("chunked_serial_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Captured operands. b is stored already inverted for subtract, so the
  // datapath is always a plain add.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
  } opnd_t;

  state_t          state, state_nx;
  opnd_t           op_q;
  logic [IDXW-1:0] idx;
  logic            accept, last;

  logic [CHUNK-1:0] a_ch, b_ch, res;
  logic [CHUNK:0]   rc;   // ripple carries; rc[CHUNK-1] is the carry into the MSB on the last slice

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (idx == LAST);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  assign a_ch  = op_q.a[int'(idx)*CHUNK +: CHUNK];
  assign b_ch  = op_q.b[int'(idx)*CHUNK +: CHUNK];
  assign rc[0] = op_q.carry;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    chunked_serial_adder_fa u_fa (
      .x  (a_ch[i]),
      .y  (b_ch[i]),
      .ci (rc[i]),
      .s  (res[i]),
      .co (rc[i+1])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      op_q  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q.a     <= a;
        op_q.b     <= sub ? ~b : b;
        op_q.carry <= sub ^ cin;
        idx        <= '0;
      end else if (state == RUN) begin
        sum[int'(idx)*CHUNK +: CHUNK] <= res;
        op_q.carry <= rc[CHUNK];
        idx        <= last ? '0 : idx + IDXW'(1);
        if (last) begin
          cout <= rc[CHUNK];
          ovf  <= rc[CHUNK] ^ rc[CHUNK-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench. It drives CHUNK = 1, 2, 4 and 8 instances (WIDTH = 8)
// in parallel from the same stimulus. Each instance is checked against an
// arithmetic reference model at its own latency of 8/CHUNK cycles.
module tb_chunked_serial_adder;
  localparam int W  = 8;
  localparam int NI = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [NI-1:0] busy, done, cout, ovf;
  logic [NI-1:0][W-1:0] sum;

  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    chunked_serial_adder #(.WIDTH(W), .CHUNK(1 << g)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy[g]), .done(done[g]), .sum(sum[g]), .cout(cout[g]), .ovf(ovf[g])
    );
  end

  // Reference model: {ovf, cout, sum}, computed with integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] ma, mb, input logic mc, ms);
    int ua, ub, sa, sb, r, sr;
    logic co, ov;
    logic [7:0] rl;
    ua = int'(ma); ub = int'(mb);
    sa = int'($signed(ma)); sb = int'($signed(mb));
    if (!ms) begin
      r = ua + ub + int'(mc); co = (r > 255); sr = sa + sb + int'(mc);
    end else begin
      r = ua - ub - int'(mc); co = (r >= 0);  sr = sa - sb - int'(mc);
    end
    ov = (sr > 127) || (sr < -128);
    rl = r[7:0];
    return {ov, co, rl};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input int g, input logic [9:0] e);
    check($sformatf("c%0d sum", 1 << g),  32'(sum[g]),  32'(e[7:0]));
    check($sformatf("c%0d cout", 1 << g), 32'(cout[g]), 32'(e[8]));
    check($sformatf("c%0d ovf", 1 << g),  32'(ovf[g]),  32'(e[9]));
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s c%0d flags", tag, 1 << g),
            32'({busy[g], done[g], cout[g], ovf[g]}), 32'(0));
      check($sformatf("%s c%0d sum", tag, 1 << g), 32'(sum[g]), 32'(0));
    end
  endtask

  // One operation, single-cycle start. Operands are scrambled during RUN to
  // show that only the captured copies matter.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
    logic [9:0] e;
    int lat;
    e = model(ta, tb, tc, ts);
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      for (int g = 0; g < NI; g++) begin
        lat = 8 >> g;
        check($sformatf("op %h%s%h c%0d k%0d busy/done", ta, ts ? "-" : "+", tb, 1 << g, k),
              32'({busy[g], done[g]}), 32'({k < lat, k == lat}));
        if (k == lat) check_result(g, e);
      end
    end
  endtask

  localparam int NH = 40;
  logic [7:0] ha [NH], hb [NH];
  logic       hc [NH], hs [NH];
  int         acc [NI];

  initial begin
    logic [7:0] corner [4];
    int lat;
    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Directed cases: wrap, signed overflow, subtract with borrow
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'h05, 8'h07, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, 1'b0, 1'b1);
    run_op(8'h10, 8'h01, 1'b1, 1'b1);

    // Signed/unsigned boundary operands
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int m = 0; m < 4; m++)
          run_op(corner[i], corner[j], m[0], m[1]);

    // start held high with new operands every cycle: each instance chains
    // accept -> RUN -> DONE -> accept and must pick up the operands present
    // on its own accept edges only.
    for (int t = 0; t < NH; t++) begin
      ha[t] = 8'($urandom); hb[t] = 8'($urandom); hc[t] = 1'($urandom); hs[t] = 1'($urandom);
    end
    ha[0] = 8'h01; hb[0] = 8'h02; hc[0] = 1'b0; hs[0] = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) acc[g] = 0;
    for (int t = 0; t < NH; t++) begin
      a = ha[t]; b = hb[t]; cin = hc[t]; sub = hs[t]; start = 1'b1;
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) begin
        lat = 8 >> g;
        if (t == acc[g] + lat) begin
          check($sformatf("held c%0d t%0d busy/done", 1 << g, t), 32'({busy[g], done[g]}), 32'(2'b01));
          check_result(g, model(ha[acc[g]], hb[acc[g]], hc[acc[g]], hs[acc[g]]));
          acc[g] = t + 1;
        end else begin
          check($sformatf("held c%0d t%0d busy/done", 1 << g, t), 32'({busy[g], done[g]}), 32'(2'b10));
        end
      end
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset one cycle after accept: outputs clear before the next edge and
    // no done pulse follows.
    a = 8'hA5; b = 8'h3C; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 check_zero("async reset");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset k%0d done", k), 32'(done), 32'(0));
    end
    run_op(8'h01, 8'h02, 1'b0, 1'b0);
    run_op(8'hC8, 8'h64, 1'b1, 1'b1);

    // Random operations
    for (int n = 0; n < 600; n++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
